// File: rtl/control_unit_pipe.sv
// control_unit_pipe: pipelined control decoder, D decode registered through E/M/W.
// Define MULTICYCLE_EN to hold MULT/AV in E for MULT_LAT/AV_LAT cycles.
module control_unit_pipe #(
   parameter int ALU_W    = 4,
   parameter int MULT_LAT = 3,
   parameter int AV_LAT   = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [5:0]       funct,
   input  logic [1:0]       opcode,
   input  logic             StallE,
   input  logic             FlushE,
   output logic [1:0]       RegSrcD,
   output logic [1:0]       ImmSrcD,
   output logic             ALUSrcE,
   output logic [ALU_W-1:0] ALUControlE,
   output logic [1:0]       FlagWE,
   output logic             BranchE,
   output logic             PlusOneE,
   output logic             IllegalE,
   output logic             MemWriteM,
   output logic             MemToRegM,
   output logic             RegWriteW,
   output logic             MemToRegW,
   output logic             StallMC
);

   localparam logic [1:0] OP_DATA = 2'b00;
   localparam logic [1:0] OP_MEM  = 2'b01;
   localparam logic [1:0] OP_BR   = 2'b10;

   localparam logic [3:0] F_NOP  = 4'b0000;
   localparam logic [3:0] F_ADD  = 4'b0100;
   localparam logic [3:0] F_SUB  = 4'b0010;
   localparam logic [3:0] F_MULT = 4'b1001;
   localparam logic [3:0] F_AV   = 4'b1010;
   localparam logic [3:0] F_PIC  = 4'b1111;

   localparam logic [ALU_W-1:0] A_ADD  = ALU_W'(1);
   localparam logic [ALU_W-1:0] A_SUB  = ALU_W'(2);
   localparam logic [ALU_W-1:0] A_MULT = ALU_W'(3);
   localparam logic [ALU_W-1:0] A_AV   = ALU_W'(4);

   if (MULT_LAT < 1 || AV_LAT < 1) begin : g_lat_check
      $error("MULT_LAT and AV_LAT must be at least 1");
   end

   typedef struct packed {
      logic             alu_src;
      logic [ALU_W-1:0] alu_ctl;
      logic [1:0]       flag_w;
      logic             branch;
      logic             plus_one;
      logic             illegal;
      logic             mem_write;
      logic             mem_to_reg;
      logic             reg_write;
   } ctl_t;

   ctl_t       dec;
   ctl_t       ex;
   logic [3:0] cmd;
   logic       m_mem_write;
   logic       m_mem_to_reg;
   logic       m_reg_write;
   logic       w_reg_write;
   logic       w_mem_to_reg;

   assign cmd = funct[4:1];

   assign RegSrcD = {opcode == OP_MEM && !funct[0], opcode == OP_BR};
   assign ImmSrcD = {opcode == OP_BR, opcode == OP_MEM};

   // D-stage decode; an undecodable word collapses to an illegal bubble
   always_comb begin
      dec = '0;
      unique case (opcode)
         OP_DATA: begin
            dec.alu_src   = funct[5];
            dec.reg_write = 1'b1;
            unique case (cmd)
               F_NOP:   dec.reg_write = 1'b0;
               F_ADD:   dec.alu_ctl = A_ADD;
               F_SUB:   dec.alu_ctl = A_SUB;
               F_MULT:  dec.alu_ctl = A_MULT;
               F_AV:    dec.alu_ctl = A_AV;
               F_PIC:   dec.reg_write = 1'b0;
               default: dec.illegal = 1'b1;
            endcase
            dec.flag_w = {funct[0],
                          funct[0] && (cmd == F_ADD || cmd == F_SUB)};
            if (dec.illegal) begin
               dec         = '0;
               dec.illegal = 1'b1;
            end
         end
         OP_MEM: begin
            dec.alu_src    = 1'b1;
            dec.alu_ctl    = funct[3] ? A_ADD : A_SUB;
            dec.plus_one   = funct[4];
            dec.mem_write  = !funct[0];
            dec.mem_to_reg = funct[0];
            dec.reg_write  = funct[0];
         end
         OP_BR: begin
            dec.alu_src = 1'b1;
            dec.alu_ctl = A_ADD;
            dec.branch  = 1'b1;
         end
         default: dec.illegal = 1'b1;
      endcase
   end

   // E/M/W registers: flush beats stall, a held multi-cycle op feeds M bubbles
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ex           <= '0;
         m_mem_write  <= 1'b0;
         m_mem_to_reg <= 1'b0;
         m_reg_write  <= 1'b0;
         w_reg_write  <= 1'b0;
         w_mem_to_reg <= 1'b0;
      end else if (FlushE) begin
         ex           <= '0;
         m_mem_write  <= ex.mem_write && !StallMC;
         m_mem_to_reg <= ex.mem_to_reg && !StallMC;
         m_reg_write  <= ex.reg_write && !StallMC;
         w_reg_write  <= m_reg_write;
         w_mem_to_reg <= m_mem_to_reg;
      end else if (!StallE) begin
         w_reg_write  <= m_reg_write;
         w_mem_to_reg <= m_mem_to_reg;
         if (StallMC) begin
            m_mem_write  <= 1'b0;
            m_mem_to_reg <= 1'b0;
            m_reg_write  <= 1'b0;
         end else begin
            m_mem_write  <= ex.mem_write;
            m_mem_to_reg <= ex.mem_to_reg;
            m_reg_write  <= ex.reg_write;
            ex           <= dec;
         end
      end
   end

   assign ALUSrcE     = ex.alu_src;
   assign ALUControlE = ex.alu_ctl;
   assign FlagWE      = ex.flag_w;
   assign BranchE     = ex.branch;
   assign PlusOneE    = ex.plus_one;
   assign IllegalE    = ex.illegal;
   assign MemWriteM   = m_mem_write;
   assign MemToRegM   = m_mem_to_reg;
   assign RegWriteW   = w_reg_write;
   assign MemToRegW   = w_mem_to_reg;

`ifdef MULTICYCLE_EN
   localparam int MAX_LAT = (MULT_LAT > AV_LAT) ? MULT_LAT : AV_LAT;
   localparam int CW      = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

   typedef enum logic {IDLE, BUSY} state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic [CW-1:0] last;
   logic          dec_multi;

   assign last = (ex.alu_ctl == A_MULT) ? CW'(MULT_LAT - 1)
                                        : CW'(AV_LAT - 1);
   assign dec_multi = (dec.alu_ctl == A_MULT && MULT_LAT > 1) ||
                      (dec.alu_ctl == A_AV && AV_LAT > 1);
   assign StallMC = (state == BUSY) && (cnt < last);

   // sequencer: arm as a long op enters E, count its extra E cycles
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
      end else if (FlushE) begin
         state <= IDLE;
         cnt   <= '0;
      end else if (!StallE) begin
         if (StallMC) begin
            cnt <= cnt + CW'(1);
         end else begin
            state <= dec_multi ? BUSY : IDLE;
            cnt   <= '0;
         end
      end
   end
`else
   assign StallMC = 1'b0;
`endif

endmodule
